bit_serial_adder: RTL and testbench

- LSB-first bit-serial adder of two WIDTH-bit operands, one bit per clock.
- Built around the team's single-bit full-adder function (sum = a^b^c, carry = ab|bc|ca) plus a registered carry.
- Operands are loaded in parallel with a start/busy/done handshake.
- Downstream consumers read the parallel sum and carry-out after done.

---
 rtl/bit_serial_adder_if.sv | 24 ++
 rtl/bit_serial_adder.sv | 121 ++++++++++++
 tb/tb_bit_serial_adder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns busy, done and the result.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder evaluation per clock with a registered carry.
// Operands load in parallel on start; sum_out/cout are registered and update only with done.
module bit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Returns {carry, sum} for one bit position.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (b & c) | (c & a), a ^ b ^ c};
  endfunction

  // Shift a new sum bit into the MSB; written without a slice so WIDTH=1 stays legal.
  function automatic logic [WIDTH-1:0] shift_in(input logic s, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r            = v >> 1;
    r[WIDTH-1]   = s;
    shift_in     = r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       fa_s;

  assign fa_s = full_add(a_q[0], b_q[0], carry_q);

  // Next-state and datapath for IDLE/SHIFT; done defaults low so it pulses for one cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin;
          cnt_d   = {CNT_W{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        s_d     = shift_in(fa_s[0], s_q);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_s[1];
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = shift_in(fa_s[0], s_q);
          cout_d  = fa_s[1];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
  end

  // State, datapath and registered outputs; reset discards any in-flight addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum_out = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: WIDTH=8 handshake/reset/back-to-back cases and a WIDTH=1 truth-table sweep.
module tb_bit_serial_adder;

  typedef struct {
    logic [8:0] val;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   busy_cnt8;
  exp_t q8[$];
  exp_t q1[$];

  bit_serial_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_if #(.WIDTH(1)) bus1 ();

  bit_serial_adder #(.WIDTH(8), .CNT_W(6)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_adder #(.WIDTH(1), .CNT_W(6)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor for both instances, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt8 = 0;
    end else begin
      if (bus8.busy) busy_cnt8 = busy_cnt8 + 1;
      if (bus8.done) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          check("sum8", 32'(bus8.sum_out), 32'(e.val[7:0]));
          check("cout8", 32'(bus8.cout), 32'(e.val[8]));
          check("latency8", 32'(cyc - e.cyc), 32'd8);
        end
        check("busy_cycles8", 32'(busy_cnt8), 32'd8);
        busy_cnt8 = 0;
      end
      if (bus1.done) begin
        if (q1.size() == 0) begin
          check("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          check("sum_cout1", 32'({bus1.cout, bus1.sum_out}), 32'(e.val[1:0]));
          check("latency1", 32'(cyc - e.cyc), 32'd1);
        end
      end
    end
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a_in  = a;
    bus8.b_in  = b;
    bus8.cin   = ci;
    @(posedge clk);
    #1;
    q8.push_back('{val: 9'(a) + 9'(b) + 9'(ci), cyc: cyc});
    bus8.start = 1'b0;
  endtask

  task automatic start1(input logic a, input logic b, input logic ci);
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a_in  = a;
    bus1.b_in  = b;
    bus1.cin   = ci;
    @(posedge clk);
    #1;
    q1.push_back('{val: 9'(a) + 9'(b) + 9'(ci), cyc: cyc});
    bus1.start = 1'b0;
  endtask

  task automatic wait_done8();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done) seen = 1'b1;
    end
    if (!seen) check("timeout_done8", 32'd0, 32'd1);
  endtask

  task automatic wait_done1();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus1.done) seen = 1'b1;
    end
    if (!seen) check("timeout_done1", 32'd0, 32'd1);
  endtask

  initial begin
    int t1;
    cyc        = 0;
    n_vec      = 0;
    n_err      = 0;
    busy_cnt8  = 0;
    rst_n      = 1'b0;
    bus8.start = 1'b0; bus8.a_in = 8'h00; bus8.b_in = 8'h00; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a_in = 1'b0;  bus1.b_in = 1'b0;  bus1.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs8", 32'({bus8.busy, bus8.done, bus8.cout, bus8.sum_out}), 32'd0);
    check("rst_outs1", 32'({bus1.busy, bus1.done, bus1.cout, bus1.sum_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, carry-out cases.
    start8(8'h5A, 8'h3C, 1'b0);
    wait_done8();
    repeat (3) @(negedge clk);
    check("hold_sum8", 32'(bus8.sum_out), 32'h96);
    start8(8'hFF, 8'h01, 1'b0);
    wait_done8();
    start8(8'hFF, 8'hFF, 1'b1);
    wait_done8();

    // Start and operand changes while busy are ignored.
    start8(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus8.start = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.cin = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    wait_done8();
    @(negedge clk);
    check("busy_after8", 32'(bus8.busy), 32'd0);
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-operation.
    start8(8'h80, 8'h80, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_outs8", 32'({bus8.busy, bus8.done, bus8.cout, bus8.sum_out}), 32'd0);
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_rst8", 32'({bus8.busy, bus8.done}), 32'd0);
    start8(8'h80, 8'h80, 1'b0);
    wait_done8();

    // Back-to-back with start held high.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = 8'h01; bus8.b_in = 8'h02; bus8.cin = 1'b0;
    @(posedge clk);
    #1;
    q8.push_back('{val: 9'h003, cyc: cyc});
    bus8.a_in = 8'h10; bus8.b_in = 8'h20;
    wait_done8();
    t1 = cyc;
    @(posedge clk);
    #1;
    q8.push_back('{val: 9'h030, cyc: cyc});
    bus8.start = 1'b0;
    wait_done8();
    check("b2b_gap8", 32'(cyc - t1), 32'd9);

    // WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      start1(i[2], i[1], i[0]);
      wait_done1();
    end

    repeat (4) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
